// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with an integrated transmit FIFO.
//               Characters enter through a valid/ready write port and are
//               serialised LSB first on tx, back-to-back with no idle gap.
//               Baud divisor, data width, parity and stop bits are set by
//               parameters.
// Ports       : clk        - system clock, all logic on posedge
//               rst_n      - synchronous active-low reset
//               wr_data    - character to enqueue
//               wr_valid   - wr_data valid
//               wr_ready   - FIFO can accept a character this cycle
//               fifo_count - entries queued, excluding the frame on the line
//               busy       - a frame is on the line
//               tx         - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_CLK_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_BAUD_W      = $clog2(c_CLK_PER_BIT);
    localparam int c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W       = c_PTR_W + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLK_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [3:0]          c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]          c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]          c_BIT_ONE   = 4'd1;
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);

    // ------------------------------------------------------------------
    // Line state machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [3:0]           r_bit;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_done;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // ------------------------------------------------------------------
    // Handshake and pop decision
    // ------------------------------------------------------------------
    // Readiness looks only at the registered count, so a full FIFO refuses
    // a write even when the line pops an entry on the same edge.
    assign wr_ready    = rst_n && (r_count < c_FULL);
    assign w_push      = wr_valid && wr_ready;

    assign w_baud_done = (r_baud == c_BAUD_LAST);
    // Final edge of the last stop bit: the next frame may start here.
    assign w_frame_end = (r_state == S_STOP) && w_baud_done && (r_bit == c_STOP_LAST);

    // An entry written on this same edge is not yet counted, so it cannot
    // be popped until the following edge.
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);

    assign w_head      = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Parity of the character at the FIFO head, latched with the pop
    // ------------------------------------------------------------------
    generate
        if (PARITY == 1) begin : g_par_odd
            assign w_head_par = ~(^w_head);
        end else if (PARITY == 2) begin : g_par_even
            assign w_head_par = ^w_head;
        end else begin : g_par_none
            assign w_head_par = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO storage; writes are already qualified by rst_n via wr_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy; pointers wrap naturally at the power of
    // two depth, full/empty are told apart by the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser. Every bit period starts on the edge that changes tx and
    // lasts c_CLK_PER_BIT cycles: r_baud restarts at zero on that edge and
    // the period ends on the edge where it reads c_BAUD_LAST.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_head_par;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_baud  <= r_baud + c_BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == c_DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + c_BIT_ONE;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud  <= r_baud + c_BAUD_ONE;
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == c_STOP_LAST) begin
                            r_bit <= '0;
                            // Chain straight into the next start bit when
                            // more data is waiting: no idle-high cycle.
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_par   <= w_head_par;
                                r_tx    <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_bit <= r_bit + c_BIT_ONE;
                            r_tx  <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo. Four instances cover
//               8N1, 8E1, 8O1 and 7N2 at 10 clocks per bit with a 4-deep
//               FIFO. Stimulus pushes hand-computed line waveforms into a
//               queue; a monitor decodes the selected tx line and compares
//               every clock of every frame against the queued waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    typedef struct {
        logic [15:0] bits;   // line levels per bit period, bit 0 = start bit
        int          nbits;
        bit          b2b;    // must start with zero idle cycles after previous
        bit          aborts; // reset is expected to cut this frame short
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] wd;
    logic [3:0] wv;
    logic [3:0] rdy;
    logic [3:0] bsy;
    logic [3:0] txv;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    int   n_vec = 0;
    int   n_err = 0;
    int   sel   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[7:0]), .wr_valid(wv[0]),
        .wr_ready(rdy[0]), .fifo_count(cnt0), .busy(bsy[0]), .tx(txv[0]));

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[7:0]), .wr_valid(wv[1]),
        .wr_ready(rdy[1]), .fifo_count(cnt1), .busy(bsy[1]), .tx(txv[1]));

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[7:0]), .wr_valid(wv[2]),
        .wr_ready(rdy[2]), .fifo_count(cnt2), .busy(bsy[2]), .tx(txv[2]));

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd[6:0]), .wr_valid(wv[3]),
        .wr_ready(rdy[3]), .fifo_count(cnt3), .busy(bsy[3]), .tx(txv[3]));

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input logic [15:0] bits, input int nbits,
                                     input bit b2b, input bit aborts);
        exp_t e;
        e.bits   = bits;
        e.nbits  = nbits;
        e.b2b    = b2b;
        e.aborts = aborts;
        exp_q.push_back(e);
    endfunction

    // Single-cycle write; returns 1 ns after the accept edge.
    task automatic put1(input int k, input logic [8:0] d);
        wd    = d;
        wv[k] = 1'b1;
        @(posedge clk); #1;
        wv[k] = 1'b0;
    endtask

    // Counts cycles busy stays high, starting from the current sample point.
    task automatic busy_len(input int k, output int len);
        len = 0;
        while (bsy[k] && len < 2000) begin
            len++;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bsy != 4'd0) && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d frames still queued, expected 0", exp_q.size());
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples the selected line on the falling edge, away from the
    // active edge. A low level on an idle line marks the first start cycle.
    // ------------------------------------------------------------------
    initial begin : monitor
        int   idle;
        int   bad;
        bit   ab;
        exp_t e;
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || txv[sel] !== 1'b0) begin
                idle++;
            end else begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame dut%0d: got a start bit, expected idle line (t=%0t)",
                             sel, $time);
                    for (int t = 0; t < 2000 && txv[sel] === 1'b0; t++) @(negedge clk);
                end else begin
                    e   = exp_q.pop_front();
                    bad = 0;
                    ab  = 1'b0;
                    if (e.b2b) chk("interframe_gap", idle, 0);
                    for (int j = 0; j < e.nbits * CPB; j++) begin
                        if (j > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            ab = 1'b1;
                            break;
                        end
                        if (txv[sel] !== e.bits[j / CPB]) bad++;
                    end
                    n_vec++;
                    if (bad != 0 || ab != e.aborts) begin
                        n_err++;
                        $display("FAIL frame dut%0d exp_bits=%h: got %0d wrong cycles abort=%0d, required 0 wrong cycles abort=%0d",
                                 sel, e.bits, bad, ab, e.aborts);
                    end
                end
                idle = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int          len;
        int          tries;
        logic [6:0]  wrap_data [10];

        wrap_data = '{7'h01, 7'h12, 7'h23, 7'h34, 7'h45, 7'h56, 7'h67, 7'h78, 7'h09, 7'h7F};
        rst_n = 1'b0;
        wd    = '0;
        wv    = '0;
        sel   = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", txv[0], 1);
        chk("reset_busy", bsy[0], 0);
        chk("reset_count", cnt0, 0);
        chk("reset_wr_ready", rdy[0], 0);
        rst_n = 1'b1;
        #1;
        chk("wr_ready_after_reset", rdy[0], 1);

        // Single 0x55, 8N1: stop, data, start
        sel = 0;
        push_exp({1'b1, 8'h55, 1'b0}, 10, 1'b0, 1'b0);
        put1(0, 9'h055);
        chk("t1_count_after_accept", cnt0, 1);
        chk("t1_tx_at_accept", txv[0], 1);
        @(posedge clk); #1;
        chk("t1_tx_low_latency", txv[0], 0);
        chk("t1_busy_start", bsy[0], 1);
        chk("t1_count_after_pop", cnt0, 0);
        busy_len(0, len);
        chk("t1_busy_cycles", len, 100);
        chk("t1_count_end", cnt0, 0);
        drain();

        // 0x07 even parity -> parity 1
        sel = 1;
        push_exp({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        put1(1, 9'h007);
        @(posedge clk); #1;
        busy_len(1, len);
        chk("t2_even_busy_cycles", len, 110);
        drain();

        // 0x07 odd parity -> parity 0
        sel = 2;
        push_exp({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        put1(2, 9'h007);
        @(posedge clk); #1;
        busy_len(2, len);
        chk("t2_odd_busy_cycles", len, 110);
        drain();

        // Back-to-back "AB"
        sel = 0;
        push_exp({1'b1, 8'h41, 1'b0}, 10, 1'b0, 1'b0);
        push_exp({1'b1, 8'h42, 1'b0}, 10, 1'b1, 1'b0);
        wd = 9'h041; wv[0] = 1'b1;
        @(posedge clk); #1;
        wd = 9'h042;
        @(posedge clk); #1;
        wv[0] = 1'b0;
        drain();

        // Overflow: six cycles of valid, 0x15 must be refused
        push_exp({1'b1, 8'h10, 1'b0}, 10, 1'b0, 1'b0);
        push_exp({1'b1, 8'h11, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h12, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h13, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h14, 1'b0}, 10, 1'b1, 1'b0);
        wd = 9'h010; wv[0] = 1'b1;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            wd = 9'(16 + i);
        end
        chk("t4_count_full", cnt0, 4);
        chk("t4_wr_ready_full", rdy[0], 0);
        @(posedge clk); #1;
        wv[0] = 1'b0;
        chk("t4_count_after_reject", cnt0, 4);
        drain();

        // Reset during DATA bit 3 of 0x5A with 0x3C queued behind it
        push_exp({1'b1, 8'h5A, 1'b0}, 10, 1'b0, 1'b1);
        put1(0, 9'h05A);
        put1(0, 9'h03C);
        chk("t5_tx_start", txv[0], 0);
        repeat (44) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_tx_after_reset", txv[0], 1);
        chk("t5_busy_after_reset", bsy[0], 0);
        chk("t5_count_after_reset", cnt0, 0);
        repeat (300) @(posedge clk);
        #1;
        chk("t5_busy_later", bsy[0], 0);
        chk("t5_count_later", cnt0, 0);

        // 7N2, 0x41
        sel = 3;
        push_exp({2'b11, 7'h41, 1'b0}, 10, 1'b0, 1'b0);
        put1(3, 9'h041);
        @(posedge clk); #1;
        chk("t6_tx_low", txv[3], 0);
        busy_len(3, len);
        chk("t6_busy_cycles", len, 100);
        drain();

        // Wrap: ten bytes through the 4-deep FIFO
        for (int i = 0; i < 10; i++) begin
            push_exp({2'b11, wrap_data[i], 1'b0}, 10, (i > 0), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            wd    = {2'b00, wrap_data[i]};
            wv[3] = 1'b1;
            tries = 0;
            while (!rdy[3] && tries < 5000) begin
                @(posedge clk); #1;
                tries++;
            end
            if (tries >= 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL wrap_write_timeout: got wr_ready 0 for %0d cycles, expected 1", tries);
            end
            @(posedge clk); #1;
        end
        wv[3] = 1'b0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It replaces the fixed 8N1 transmitter and its separate buffer wrapper with one block. Upstream logic pushes characters through a valid/ready write port. The block serialises them on tx back-to-back, with configurable baud divisor, data width, parity and stop bits. It sits between the main machine-state logic and the board UART pin.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLK_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries, power of two, >= 2

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
wr_data  input  DATA_BITS  character to enqueue
wr_valid  input  1  wr_data valid
wr_ready  output  1  FIFO can accept; wr_ready = rst_n && (fifo_count < FIFO_DEPTH)
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued, not counting the frame on the line
busy  output  1  high whenever a frame is on the line (state != IDLE)
tx  output  1  serial line, registered, idle high

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- While rst_n = 0 at a posedge, the following are forced:
  - tx = 1, busy = 0, fifo_count = 0
  - read and write pointers = 0, state = IDLE
  - bit and baud counters cleared
- Reset mid-frame aborts the frame: tx is high from the next cycle and queued data is discarded.
- Write handshake: an entry is accepted on a posedge with wr_valid && wr_ready. fifo_count increments at that edge.
  - wr_ready uses the registered count only. When full, a write is rejected even if a pop happens in the same cycle.
  - A write while not ready is ignored. No overwrite, no error flag.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_count.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each bit period is exactly CLK_PER_BIT cycles, counted from the edge at which tx changes.
  - IDLE: if fifo_count != 0, pop at this edge, load the shift register, compute parity, tx <= 0, go to START. Otherwise tx <= 1.
  - START to DATA after CLK_PER_BIT cycles. tx <= data[0].
  - DATA shifts LSB first. After DATA_BITS periods, go to PARITY if PARITY != 0, else STOP.
  - PARITY bit makes the total count of ones (data + parity) odd (PARITY = 1) or even (PARITY = 2).
  - STOP: tx = 1 for STOP_BITS*CLK_PER_BIT cycles. At the final edge, if fifo_count != 0, pop and go directly to START with tx <= 0 (zero idle gap). Otherwise go to IDLE.
- Latency: a write accepted at edge N into an idle, empty block drives tx low after edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLK_PER_BIT cycles.
- Data popped into the shift register is immune to later FIFO writes.
- Counter widths: baud counter is $clog2(CLK_PER_BIT) bits; bit counter is 4 bits. No counter overflows for legal parameters.

Test Plan:
Test parameters unless stated: CLK_FREQ = 1000, BAUD = 100 (CLK_PER_BIT = 10), DATA_BITS = 8, FIFO_DEPTH = 4.
1. Single byte 0x55, 8N1:
   - tx low 1 cycle after the accept edge.
   - Then bits 1,0,1,0,1,0,1,0, then stop 1, each exactly 10 cycles; 100-cycle frame.
   - busy high for 100 cycles; fifo_count returns to 0.
2. PARITY = 2, data 0x07: parity bit = 1. PARITY = 1, data 0x07: parity bit = 0. Frame is 110 cycles.
3. Back-to-back "AB": 'B' start bit begins on the cycle immediately after 'A' stop ends, with no extra high cycle.
4. Overflow, with wr_valid held high for 6 consecutive cycles:
   - 1st entry pops at once; the next 4 fill the FIFO (fifo_count = 4) and wr_ready drops.
   - 6th write is not accepted.
   - Exactly 5 frames are emitted, in order.
5. Reset mid-frame:
   - rst_n low for 1 cycle during DATA bit 3: tx = 1, busy = 0, fifo_count = 0 on the next cycle.
   - No further frames are emitted.
6. STOP_BITS = 2, DATA_BITS = 7, data 0x41: 7 data bits, stop high for 20 cycles, 100-cycle frame. Wrap check: 10 sequential bytes through depth 4 arrive intact and in order.
